// File: rtl/weight_update1.sv
// rtl/weight_update1.sv - layer-1 weight/bias read-modify-write for one hidden neuron per start.
// Define WEIGHT_UPDATE1_SAT_EN for a saturating update; otherwise the update wraps.
module weight_update1 #(
  parameter int NWBITS     = 16,
  parameter int NPIXEL     = 784,
  parameter int NHIDDEN    = 64,
  parameter int COUNT_BIT1 = 10,
  parameter int NIDX_BITS  = 6,
  parameter int ADDR_BITS  = 16
) (
  input  logic                 clk,
  input  logic                 reset_b,
  input  logic                 start_state6,
  input  logic [NIDX_BITS-1:0] neuron_idx,
  input  logic [NWBITS-1:0]    delta_weight,
  input  logic [NWBITS-1:0]    delta_bias,
  input  logic [NWBITS-1:0]    bias_rd_data,
  output logic                 w_rd_en,
  output logic [ADDR_BITS-1:0] w_rd_addr,
  input  logic [NWBITS-1:0]    w_rd_data,
  output logic                 w_wr_en,
  output logic [ADDR_BITS-1:0] w_wr_addr,
  output logic [NWBITS-1:0]    w_wr_data,
  output logic                 bias_wr_en,
  output logic [NWBITS-1:0]    bias_wr_data,
  output logic                 busy,
  output logic                 done
);

  if (ADDR_BITS < $clog2(NHIDDEN * NPIXEL)) begin : g_bad_cfg
    $error("weight_update1: ADDR_BITS too narrow for NHIDDEN*NPIXEL");
  end

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t                state, next_state;
  logic [COUNT_BIT1-1:0] rd_cnt;
  logic                  drain_cnt;
  logic [ADDR_BITS-1:0]  base;
  logic [ADDR_BITS-1:0]  start_base;
  logic                  p1_v;
  logic [ADDR_BITS-1:0]  p1_addr;
  logic                  rd_last;

  function automatic logic [NWBITS-1:0] upd(input logic [NWBITS-1:0] w,
                                            input logic [NWBITS-1:0] d);
`ifdef WEIGHT_UPDATE1_SAT_EN
    logic [NWBITS:0] diff;
    diff = {w[NWBITS-1], w} - {d[NWBITS-1], d};
    if (diff[NWBITS] != diff[NWBITS-1])
      upd = diff[NWBITS] ? {1'b1, {(NWBITS-1){1'b0}}} : {1'b0, {(NWBITS-1){1'b1}}};
    else
      upd = diff[NWBITS-1:0];
`else
    upd = w - d;
`endif
  endfunction

  assign start_base = ADDR_BITS'(neuron_idx) * ADDR_BITS'(NPIXEL);
  assign rd_last    = (state == READ) && (rd_cnt == COUNT_BIT1'(NPIXEL));

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start_state6) next_state = READ;
      READ:    if (rd_last)      next_state = DRAIN;
      DRAIN:   if (drain_cnt)    next_state = IDLE;
      default:                   next_state = IDLE;
    endcase
  end

  // Write side trails the read side by two edges: one for the RAM's read latency, one to register the result.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rd_cnt       <= '0;
      drain_cnt    <= 1'b0;
      base         <= '0;
      p1_v         <= 1'b0;
      p1_addr      <= '0;
      w_rd_en      <= 1'b0;
      w_rd_addr    <= '0;
      w_wr_en      <= 1'b0;
      w_wr_addr    <= '0;
      w_wr_data    <= '0;
      bias_wr_en   <= 1'b0;
      bias_wr_data <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      bias_wr_en <= 1'b0;
      done       <= 1'b0;
      p1_v       <= w_rd_en;
      p1_addr    <= w_rd_addr;
      w_wr_en    <= p1_v;
      if (p1_v) begin
        w_wr_addr <= p1_addr;
        w_wr_data <= upd(w_rd_data, delta_weight);
      end
      case (state)
        IDLE: begin
          if (start_state6) begin
            base      <= start_base;
            w_rd_en   <= 1'b1;
            w_rd_addr <= start_base;
            rd_cnt    <= COUNT_BIT1'(1);
            drain_cnt <= 1'b0;
            busy      <= 1'b1;
          end
        end
        READ: begin
          if (rd_cnt == COUNT_BIT1'(1)) begin
            bias_wr_en   <= 1'b1;
            bias_wr_data <= upd(bias_rd_data, delta_bias);
          end
          if (rd_last) begin
            w_rd_en <= 1'b0;
          end else begin
            w_rd_addr <= base + ADDR_BITS'(rd_cnt);
            rd_cnt    <= rd_cnt + COUNT_BIT1'(1);
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (!drain_cnt) done <= 1'b1;
          else            busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_update1.sv
// tb/tb_weight_update1.sv - randomized bench for weight_update1 against a whole-row arithmetic model.
module tb_weight_update1;
  localparam int NW = 16;
  localparam int NP = 784;
  localparam int NH = 64;

  logic          clk = 1'b0;
  logic          reset_b = 1'b0;
  logic          start_state6 = 1'b0;
  logic [5:0]    neuron_idx = '0;
  logic [NW-1:0] delta_weight = '0;
  logic [NW-1:0] delta_bias = '0;
  logic [NW-1:0] bias_rd_data = '0;
  logic          w_rd_en;
  logic [15:0]   w_rd_addr;
  logic [NW-1:0] w_rd_data;
  logic          w_wr_en;
  logic [15:0]   w_wr_addr;
  logic [NW-1:0] w_wr_data;
  logic          bias_wr_en;
  logic [NW-1:0] bias_wr_data;
  logic          busy;
  logic          done;

  weight_update1 dut (
    .clk(clk), .reset_b(reset_b), .start_state6(start_state6), .neuron_idx(neuron_idx),
    .delta_weight(delta_weight), .delta_bias(delta_bias), .bias_rd_data(bias_rd_data),
    .w_rd_en(w_rd_en), .w_rd_addr(w_rd_addr), .w_rd_data(w_rd_data),
    .w_wr_en(w_wr_en), .w_wr_addr(w_wr_addr), .w_wr_data(w_wr_data),
    .bias_wr_en(bias_wr_en), .bias_wr_data(bias_wr_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   addr;
    logic [NW-1:0] data;
    logic [NW-1:0] old;
  } wr_t;

  logic [NW-1:0] ram     [0:NP*NH-1];
  logic [NW-1:0] ref_mem [0:NP*NH-1];
  logic [NW-1:0] ram_q = '0;
  logic [NW-1:0] dw      [0:NP-1];
  wr_t           exp_q[$];
  wr_t           mon_e;
  int            nvec = 0;
  int            nerr = 0;
  int            done_cnt = 0;
  int            d0;

  assign w_rd_data = ram_q;

  always @(posedge clk) begin
    if (w_rd_en) ram_q <= ram[w_rd_addr];
    if (w_wr_en) ram[w_wr_addr] <= w_wr_data;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [NW-1:0] ref_upd(input logic [NW-1:0] w, input logic [NW-1:0] d);
    int r;
    r = int'($signed(w)) - int'($signed(d));
`ifdef WEIGHT_UPDATE1_SAT_EN
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
`endif
    return 16'(r);
  endfunction

  always @(negedge clk) begin
    if (reset_b) begin
      if (w_wr_en) begin
        if (exp_q.size() == 0) begin
          chk("wr_extra", 32'(exp_q.size()), 32'd1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_addr", 32'(w_wr_addr), 32'(mon_e.addr));
          chk("wr_data", 32'(w_wr_data), 32'(mon_e.data));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_last", 32'(exp_q.size()), 32'd0);
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rd_en"},   32'(w_rd_en), 32'd0);
    chk({tag, "_rd_addr"}, 32'(w_rd_addr), 32'd0);
    chk({tag, "_wr_en"},   32'(w_wr_en), 32'd0);
    chk({tag, "_wr_addr"}, 32'(w_wr_addr), 32'd0);
    chk({tag, "_wr_data"}, 32'(w_wr_data), 32'd0);
    chk({tag, "_b_en"},    32'(bias_wr_en), 32'd0);
    chk({tag, "_b_data"},  32'(bias_wr_data), 32'd0);
    chk({tag, "_busy"},    32'(busy), 32'd0);
    chk({tag, "_done"},    32'(done), 32'd0);
  endtask

  // Row model: every pixel k of the row becomes old - dw[k]; bias becomes bias - dbias.
  task automatic run_row(input int idx, input logic [NW-1:0] bias, input logic [NW-1:0] dbias,
                         input int spur, input int abort_at);
    int            base;
    int            m;
    int            ea;
    logic [NW-1:0] exp_bias;
    wr_t           e;
    base = idx * NP;
    for (int k = 0; k < NP; k++) begin
      e.addr = 16'(base + k);
      e.old  = ref_mem[base + k];
      e.data = ref_upd(e.old, dw[k]);
      ref_mem[base + k] = e.data;
      exp_q.push_back(e);
    end
    exp_bias     = ref_upd(bias, dbias);
    start_state6 = 1'b1;
    neuron_idx   = 6'(idx);
    bias_rd_data = bias;
    delta_bias   = dbias;
    delta_weight = 16'($urandom);
    @(posedge clk);
    for (int n = 1; n <= NP + 2; n++) begin
      @(negedge clk);
      m  = n - 1;
      ea = base + ((m < NP) ? m : NP - 1);
      chk("busy",    32'(busy), 32'd1);
      chk("done",    32'(done), 32'(m == NP + 1));
      chk("rd_en",   32'(w_rd_en), 32'(m <= NP - 1));
      chk("rd_addr", 32'(w_rd_addr), 32'(ea));
      chk("wr_en",   32'(w_wr_en), 32'(m >= 2 && m <= NP + 1));
      chk("bias_en", 32'(bias_wr_en), 32'(m == 1));
      if (m == 1) chk("bias_data", 32'(bias_wr_data), 32'(exp_bias));
      start_state6 = (n == spur);
      if (n == spur) neuron_idx = 6'($urandom);
      if (n >= 2) begin
        bias_rd_data = 16'($urandom);
        delta_bias   = 16'($urandom);
      end
      delta_weight = (n >= 2 && n <= NP + 1) ? dw[n-2] : 16'($urandom);
      @(posedge clk);
      if (n == abort_at) begin
        #2 reset_b = 1'b0;
        start_state6 = 1'b0;
        @(negedge clk);
        chk_all_zero("abort");
        while (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          ref_mem[e.addr] = e.old;
        end
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (5) begin
          @(negedge clk);
          chk("post_rst_wr_en", 32'(w_wr_en), 32'd0);
          chk("post_rst_busy",  32'(busy), 32'd0);
        end
        return;
      end
    end
    @(negedge clk);
    chk("end_busy",  32'(busy), 32'd0);
    chk("end_done",  32'(done), 32'd0);
    chk("end_wr_en", 32'(w_wr_en), 32'd0);
    #1 chk("end_queue", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < NP * NH; i++) begin
      ram[i] = ((i / NP) inside {1, 2, 4, 6}) ? 16'($urandom) : 16'd100;
    end
    ram[3*NP]     = 16'sd32760;
    ram[3*NP + 1] = -16'sd32760;
    for (int i = 0; i < NP * NH; i++) ref_mem[i] = ram[i];

    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_b = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_wr_en", 32'(w_wr_en), 32'd0);
      chk("idle_busy",  32'(busy), 32'd0);
    end

    d0 = done_cnt;
    for (int k = 0; k < NP; k++) dw[k] = 16'd4;
    run_row(0, 16'($urandom), 16'($urandom), 0, 0);
    for (int k = 0; k < NP; k++) dw[k] = 16'($urandom);
    run_row(1, 16'($urandom), 16'($urandom), 0, 0);
    chk("b2b_done", 32'(done_cnt - d0), 32'd2);
    chk("row0_w0", 32'(ram[0]), 32'd96);

    for (int k = 0; k < NP; k++) dw[k] = 16'(k % 16);
    run_row(5, 16'd50, 16'hFFFD, 0, 0);
    chk("row5_w17", 32'(ram[5*NP + 17]), 32'd99);

    for (int k = 0; k < NP; k++) dw[k] = 16'($urandom);
    dw[0] = -16'sd16;
    dw[1] = 16'sd16;
    run_row(3, 16'($urandom), 16'($urandom), 0, 0);
`ifdef WEIGHT_UPDATE1_SAT_EN
    chk("sat_hi", 32'(ram[3*NP]),     32'h7FFF);
    chk("sat_lo", 32'(ram[3*NP + 1]), 32'h8000);
`else
    chk("wrap_hi", 32'(ram[3*NP]),     32'h8008);
    chk("wrap_lo", 32'(ram[3*NP + 1]), 32'h7FF8);
`endif

    d0 = done_cnt;
    for (int k = 0; k < NP; k++) dw[k] = 16'($urandom);
    run_row(4, 16'($urandom), 16'($urandom), 10, 0);
    chk("spur_done", 32'(done_cnt - d0), 32'd1);

    for (int k = 0; k < NP; k++) dw[k] = 16'($urandom);
    run_row(2, 16'($urandom), 16'($urandom), 0, 300);

    for (int k = 0; k < NP; k++) dw[k] = 16'($urandom);
    run_row(6, 16'($urandom), 16'($urandom), 0, 0);

    for (int i = 0; i < 8 * NP; i++) begin
      if (ram[i] !== ref_mem[i]) chk($sformatf("mem[%0d]", i), 32'(ram[i]), 32'(ref_mem[i]));
      else nvec++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
